// File: rtl/dffe_pipe_chain.sv
// ---------------------------------------------------------------------------
// dffe_pipe_chain
//   Elastic pipeline register chain: DEPTH stages of WIDTH-bit data, each
//   with its own valid bit. A global enable stalls everything, a synchronous
//   flush empties the chain, and valid/ready handshakes sit at both ends.
//   Empty stages (bubbles) collapse, so the upstream side keeps advancing
//   while the downstream side is blocked.
//
//   Stage 0 is the input side, stage DEPTH-1 the output side.
//
// Parameters
//   WIDTH      data bits per stage (>=1)
//   DEPTH      number of stages (>=1)
//   RESET_VAL  value loaded into every data register on reset and on flush
//
// Ports
//   clk        clock
//   clr_n      asynchronous active-low reset
//   en         global enable; 0 freezes every register and drops in_ready
//   flush      synchronous clear of all stages and the count
//   in_valid   upstream offers in_data
//   in_data    upstream data word
//   in_ready   stage 0 accepts this cycle (combinational from en/out_ready)
//   out_valid  valid bit of stage DEPTH-1
//   out_data   data of stage DEPTH-1
//   out_ready  downstream accepts out_data
//   stage_vld  per-stage valid bits, bit k = stage k
//   count      number of valid stages
//
// Configuration
//   DFF_PIPE_NEGEDGE_EN  when defined, every register updates on the falling
//                        edge of clk; otherwise on the rising edge. Reset is
//                        asynchronous active-low in both builds.
// ---------------------------------------------------------------------------
module dffe_pipe_chain #(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [DEPTH-1:0]           stage_vld,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  // Stage state
  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [CW-1:0]    r_count;

  // Per-stage accept and the word each stage would take in
  logic [DEPTH-1:0] w_acc;
  logic [DEPTH-1:0] w_src_vld;
  logic [WIDTH-1:0] w_src_data [DEPTH];

  logic w_in_xfer;
  logic w_out_xfer;

  // Accept chain. The recursive form acc[k] = en & (~v[k] | acc[k+1]) with
  // acc[DEPTH] = out_ready is folded into en & (out_ready | any hole at or
  // downstream of k), accumulated from the output side. The result is
  // identical but avoids a vector that feeds back on itself.
  always_comb begin
    logic w_hole;
    w_acc  = '0;
    w_hole = out_ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_hole               = w_hole | ~r_vld[DEPTH-1-i];
      w_acc[DEPTH-1-i]     = en & w_hole;
    end
  end

  // Each stage is fed by its upstream neighbour; stage 0 by the input port.
  always_comb begin
    w_src_vld     = '0;
    w_src_vld[0]  = in_valid;
    w_src_data[0] = in_data;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      w_src_vld[k]  = r_vld[k-1];
      w_src_data[k] = r_data[k-1];
    end
  end

  assign w_in_xfer  = in_valid & w_acc[0];
  assign w_out_xfer = r_vld[DEPTH-1] & out_ready & en;

  // Valid bits and data. A stage that accepts a bubble clears its valid bit
  // but keeps its stale data, so data registers only load on a real word.
`ifdef DFF_PIPE_NEGEDGE_EN
  always_ff @(negedge clk or negedge clr_n) begin
`else
  always_ff @(posedge clk or negedge clr_n) begin
`endif
    if (!clr_n) begin
      r_vld <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_data[k] <= RESET_VAL;
      end
    end else if (flush) begin
      r_vld <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_data[k] <= RESET_VAL;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_acc[k]) begin
          r_vld[k] <= w_src_vld[k];
          if (w_src_vld[k]) begin
            r_data[k] <= w_src_data[k];
          end
        end
      end
    end
  end

  // Occupancy: one in and one out in the same cycle leaves it unchanged.
`ifdef DFF_PIPE_NEGEDGE_EN
  always_ff @(negedge clk or negedge clr_n) begin
`else
  always_ff @(posedge clk or negedge clr_n) begin
`endif
    if (!clr_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready  = w_acc[0];
  assign out_valid = r_vld[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign stage_vld = r_vld;
  assign count     = r_count;

endmodule

// File: tb/tb_dffe_pipe_chain.sv
// ---------------------------------------------------------------------------
// tb_dffe_pipe_chain
//   Self-checking bench for dffe_pipe_chain with DEPTH=3, WIDTH=8 and a
//   non-zero RESET_VAL. Each table record drives one cycle of inputs and
//   holds the expected in_ready for that cycle plus the stage valid bits and
//   count after the active edge. Accepted words go into a scoreboard queue
//   and are matched against out_data as they leave. Follows the active clock
//   edge selected by DFF_PIPE_NEGEDGE_EN.
// ---------------------------------------------------------------------------
module tb_dffe_pipe_chain;

  localparam int unsigned    W  = 8;
  localparam int unsigned    D  = 3;
  localparam logic [W-1:0]   RV = 8'h5A;

  logic         clk;
  logic         clr_n;
  logic         en;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [D-1:0] stage_vld;
  logic [1:0]   count;

  dffe_pipe_chain #(
    .WIDTH    (W),
    .DEPTH    (D),
    .RESET_VAL(RV)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .stage_vld(stage_vld),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         en;
    logic         fl;
    logic         rdy;   // expected in_ready during the cycle
    logic [D-1:0] vld;   // expected stage_vld after the edge
    logic [1:0]   cnt;   // expected count after the edge
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] sb[$];
  logic [D-1:0] exp_vld;
  int           n_vec;
  int           n_err;
  int           idx;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d, t=%0t): got %0h expected %0h", nm, idx, $time, act, exp);
    end
  endfunction

  function automatic void add(input logic iv, input logic [W-1:0] id, input logic ordy,
                              input logic e, input logic fl, input logic rdy,
                              input logic [D-1:0] vld, input logic [1:0] cnt);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.en = e; v.fl = fl;
    v.rdy = rdy; v.vld = vld; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  task automatic wait_act();
`ifdef DFF_PIPE_NEGEDGE_EN
    @(negedge clk);
`else
    @(posedge clk);
`endif
  endtask

  task automatic wait_inact();
`ifdef DFF_PIPE_NEGEDGE_EN
    @(posedge clk);
`else
    @(negedge clk);
`endif
  endtask

  // Entered 1 time unit after an active edge; leaves at the same phase.
  task automatic step(input vec_t t);
    logic [W-1:0] got;
    in_valid  = t.iv;
    in_data   = t.id;
    out_ready = t.ordy;
    en        = t.en;
    flush     = t.fl;
    #1;
    chk("in_ready", in_ready, t.rdy);
    chk("out_valid", out_valid, exp_vld[D-1]);
    if (exp_vld[D-1]) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        chk("out_data", out_data, sb[0]);
      end
    end
    if (t.iv && t.rdy && !t.fl) sb.push_back(t.id);
    if (exp_vld[D-1] && t.ordy && t.en && sb.size() != 0) got = sb.pop_front();
    // Nothing may move on the inactive edge.
    wait_inact();
    #1;
    chk("hold_inactive_vld", stage_vld, exp_vld);
    wait_act();
    #1;
    if (t.fl) sb.delete();
    exp_vld = t.vld;
    chk("stage_vld", stage_vld, t.vld);
    chk("count", count, t.cnt);
    chk("count_vs_sb", count, sb.size());
    if (t.fl) chk("flush_out_data", out_data, RV);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; idx = -1;
    exp_vld = '0;

    //   iv  data   ordy en fl  rdy  vld     cnt
    // streaming at full rate, first word out 3 edges after accept
    add(1, 8'h0A, 1, 1, 0,  1, 3'b001, 2'd1);
    add(1, 8'h0B, 1, 1, 0,  1, 3'b011, 2'd2);
    add(1, 8'h0C, 1, 1, 0,  1, 3'b111, 2'd3);
    add(1, 8'h0D, 1, 1, 0,  1, 3'b111, 2'd3);
    add(1, 8'h0E, 1, 1, 0,  1, 3'b111, 2'd3);
    add(0, 8'h00, 1, 1, 0,  1, 3'b110, 2'd2);
    // fill against a blocked output, then drain
    add(1, 8'h0F, 0, 1, 0,  1, 3'b111, 2'd3);
    add(1, 8'h10, 0, 1, 0,  0, 3'b111, 2'd3);
    add(0, 8'h00, 1, 1, 0,  1, 3'b110, 2'd2);
    add(0, 8'h00, 1, 1, 0,  1, 3'b100, 2'd1);
    // bubble collapse behind a blocked output
    add(1, 8'h05, 0, 1, 0,  1, 3'b101, 2'd2);
    add(1, 8'h06, 0, 1, 0,  1, 3'b111, 2'd3);
    add(1, 8'h07, 0, 1, 0,  0, 3'b111, 2'd3);
    // stall: en=0 freezes everything
    add(1, 8'h77, 1, 0, 0,  0, 3'b111, 2'd3);
    add(1, 8'h77, 1, 0, 0,  0, 3'b111, 2'd3);
    add(1, 8'h77, 1, 0, 0,  0, 3'b111, 2'd3);
    add(1, 8'h77, 1, 0, 0,  0, 3'b111, 2'd3);
    add(0, 8'h00, 1, 1, 0,  1, 3'b110, 2'd2);
    // flush drops the word offered alongside it
    add(1, 8'h99, 0, 1, 1,  1, 3'b000, 2'd0);
    add(0, 8'h00, 1, 1, 0,  1, 3'b000, 2'd0);
    add(1, 8'h31, 1, 1, 0,  1, 3'b001, 2'd1);
    add(0, 8'h00, 1, 1, 0,  1, 3'b010, 2'd1);
    add(0, 8'h00, 1, 1, 0,  1, 3'b100, 2'd1);
    add(0, 8'h00, 1, 1, 0,  1, 3'b000, 2'd0);
    // flush while the output transfers on a full chain
    add(1, 8'h41, 1, 1, 0,  1, 3'b001, 2'd1);
    add(1, 8'h42, 1, 1, 0,  1, 3'b011, 2'd2);
    add(1, 8'h43, 1, 1, 0,  1, 3'b111, 2'd3);
    add(0, 8'h00, 1, 1, 1,  1, 3'b000, 2'd0);
    // flush wins even with en=0
    add(1, 8'h50, 1, 1, 0,  1, 3'b001, 2'd1);
    add(1, 8'h51, 0, 0, 1,  0, 3'b000, 2'd0);

    // reset state
    clr_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    wait_act();
    #1;
    chk("rst_stage_vld", stage_vld, 0);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, RV);
    chk("rst_in_ready", in_ready, 1);
    clr_n = 1'b1;

    foreach (tbl[i]) begin
      idx = i;
      step(tbl[i]);
    end

    // Asynchronous reset between edges, mid-stream
    idx = 100;
    begin
      vec_t v;
      v.ordy = 0; v.en = 1; v.fl = 0; v.rdy = 1; v.iv = 1;
      v.id = 8'h61; v.vld = 3'b001; v.cnt = 2'd1; step(v);
      v.id = 8'h62; v.vld = 3'b011; v.cnt = 2'd2; step(v);
      v.id = 8'h63; v.vld = 3'b111; v.cnt = 2'd3; step(v);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("pre_rst_out_data", out_data, 8'h61);
    chk("pre_rst_count", count, 3);
    clr_n = 1'b0;
    #1;
    chk("async_rst_stage_vld", stage_vld, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, RV);
    chk("async_rst_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h64;
    wait_act();
    #1;
    chk("rst_hold_stage_vld", stage_vld, 0);
    chk("rst_hold_count", count, 0);
    in_valid = 1'b0;
    wait_inact();
    #1;
    clr_n = 1'b1;
    sb.delete();
    exp_vld = '0;
    wait_act();
    #1;

    // Pipeline runs normally after reset release
    idx = 200;
    begin
      vec_t v;
      v.en = 1; v.fl = 0; v.rdy = 1;
      v.iv = 1; v.id = 8'h71; v.ordy = 0; v.vld = 3'b001; v.cnt = 2'd1; step(v);
      v.iv = 0; v.id = 8'h00; v.ordy = 0; v.vld = 3'b010; v.cnt = 2'd1; step(v);
      v.iv = 0;               v.ordy = 0; v.vld = 3'b100; v.cnt = 2'd1; step(v);
      v.iv = 0;               v.ordy = 1; v.vld = 3'b000; v.cnt = 2'd0; step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
